// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types and constants for the CPU-bus memory responder
package cpu_bus_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;

  localparam logic [1:0] RAM_SEL = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    RD_DONE   = 2'd2,
    WR_COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU bus plus ROM loader signals seen by the memory responder
interface mem_responder_if
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROM_AW = 10
);

  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rdy;
  logic              busy;
  logic              err;
  logic              load_we;
  logic [ROM_AW-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  modport master (
    output rd, wr, addr, data_in, load_we, load_addr, load_data,
    input  data_out, rdy, busy, err
  );

  modport slave (
    input  rd, wr, addr, data_in, load_we, load_addr, load_data,
    output data_out, rdy, busy, err
  );

endinterface

// File: rtl/resp_sync_ram.sv
// rtl/resp_sync_ram.sv - synchronous memory array, one write port and one registered read port
module resp_sync_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Read-before-write: a same-edge write to the read location returns the old byte.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - decodes CPU bus accesses into RAM/ROM with programmable read wait states
module mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RAM_AW = 8,
  parameter int ROM_AW = 10,
  parameter int RD_LAT = 2
) (
  input logic           clk1,
  input logic           rst,
  mem_responder_if.slave bus
);

  localparam int              CNT_W    = 3;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT);

  state_t              r_state, w_state_nxt;
  logic                r_rd_q, r_wr_q;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0]   r_dout, w_dout_nxt;
  logic                r_rdy, w_rdy_nxt;
  logic                r_err, w_err_nxt;

  logic                w_rd_rise, w_wr_rise;
  logic                w_is_ram, w_is_rom;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_ram_q, w_rom_q, w_rd_data;

  assign w_rd_rise = bus.rd & ~r_rd_q;
  assign w_wr_rise = bus.wr & ~r_wr_q;

  // The arrays are addressed with the live bus address while idle so the byte is
  // already in the read register by the edge that raises rdy (needed for RD_LAT=0).
  assign w_acc_addr = (r_state == IDLE) ? bus.addr : r_addr;

  assign w_is_ram  = (r_addr[ADDR_W-1 -: 2] == RAM_SEL);
  assign w_is_rom  = !w_is_ram && ((r_addr >> ROM_AW) == '0);
  assign w_rd_data = w_is_ram ? w_ram_q : (w_is_rom ? w_rom_q : '0);
  assign w_ram_we  = (r_state == WR_COMMIT) && w_is_ram && !rst;

  resp_sync_ram #(.AW(RAM_AW), .DW(DATA_W)) u_ram (
    .clk     (clk1),
    .i_we    (w_ram_we),
    .i_waddr (r_addr[RAM_AW-1:0]),
    .i_wdata (r_wdata),
    .i_raddr (w_acc_addr[RAM_AW-1:0]),
    .o_rdata (w_ram_q)
  );

  resp_sync_ram #(.AW(ROM_AW), .DW(DATA_W)) u_rom (
    .clk     (clk1),
    .i_we    (bus.load_we),
    .i_waddr (bus.load_addr),
    .i_wdata (bus.load_data),
    .i_raddr (w_acc_addr[ROM_AW-1:0]),
    .o_rdata (w_rom_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_dout_nxt  = r_dout;
    w_rdy_nxt   = r_rdy;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rd_rise && w_wr_rise) begin
          w_err_nxt = 1'b1;
        end else if (w_rd_rise) begin
          w_addr_nxt  = bus.addr;
          w_cnt_nxt   = LAT_INIT;
          w_state_nxt = RD_WAIT;
        end else if (w_wr_rise) begin
          w_addr_nxt  = bus.addr;
          w_wdata_nxt = bus.data_in;
          w_state_nxt = WR_COMMIT;
        end
      end
      RD_WAIT: begin
        w_err_nxt = w_rd_rise | w_wr_rise;
        if (!bus.rd) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_dout_nxt  = w_rd_data;
          w_rdy_nxt   = 1'b1;
          w_err_nxt   = w_err_nxt | (!w_is_ram && !w_is_rom);
          w_state_nxt = RD_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RD_DONE: begin
        w_err_nxt = w_rd_rise | w_wr_rise;
        if (!bus.rd) begin
          w_rdy_nxt   = 1'b0;
          w_dout_nxt  = '0;
          w_state_nxt = IDLE;
        end
      end
      WR_COMMIT: begin
        w_err_nxt   = w_rd_rise | w_wr_rise | !w_is_ram;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state <= IDLE;
      r_rd_q  <= 1'b0;
      r_wr_q  <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_dout  <= '0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rd_q  <= bus.rd;
      r_wr_q  <= bus.wr;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_dout  <= w_dout_nxt;
      r_rdy   <= w_rdy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.data_out = r_dout;
  assign bus.rdy      = r_rdy;
  assign bus.err      = r_err;
  assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - three responders (RD_LAT 0/2/5) driven in lockstep against an array model
module tb_mem_responder;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [12:0] addr;
  logic [7:0]  data_in;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [7:0]  load_data;

  logic        rdy_v  [3];
  logic        busy_v [3];
  logic        err_v  [3];
  logic [7:0]  dout_v [3];

  logic [7:0]  ram_m [256];
  logic [7:0]  rom_m [1024];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk1 = ~clk1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 5);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder_if #(.ADDR_W(13), .DATA_W(8), .ROM_AW(10)) bus ();
    assign bus.rd        = rd;
    assign bus.wr        = wr;
    assign bus.addr      = addr;
    assign bus.data_in   = data_in;
    assign bus.load_we   = load_we;
    assign bus.load_addr = load_addr;
    assign bus.load_data = load_data;
    assign rdy_v[g]      = bus.rdy;
    assign busy_v[g]     = bus.busy;
    assign err_v[g]      = bus.err;
    assign dout_v[g]     = bus.data_out;
    mem_responder #(.RD_LAT(lat_of(g))) dut (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus)
    );
  end

  function automatic logic [7:0] model_read(input logic [12:0] a);
    if (a >= 13'h1800) return ram_m[a[7:0]];
    if (a < 13'd1024)  return rom_m[a[9:0]];
    return 8'h00;
  endfunction

  function automatic bit model_unmapped(input logic [12:0] a);
    return (a < 13'h1800) && (a >= 13'd1024);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_rdy_lat%0d", tag, lat_of(i)), {7'd0, rdy_v[i]}, 8'd0);
      check($sformatf("%s_dout_lat%0d", tag, lat_of(i)), dout_v[i], 8'd0);
      check($sformatf("%s_busy_lat%0d", tag, lat_of(i)), {7'd0, busy_v[i]}, 8'd0);
      check($sformatf("%s_err_lat%0d", tag, lat_of(i)), {7'd0, err_v[i]}, 8'd0);
    end
  endtask

  task automatic do_write(input logic [12:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_busy_lat%0d", lat_of(i)), {7'd0, busy_v[i]}, 8'd1);
      check($sformatf("wr_err0_lat%0d", lat_of(i)), {7'd0, err_v[i]}, 8'd0);
    end
    wr = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_done_busy_lat%0d", lat_of(i)), {7'd0, busy_v[i]}, 8'd0);
      check($sformatf("wr_err_lat%0d_a%0h", lat_of(i), a), {7'd0, err_v[i]}, {7'd0, a < 13'h1800});
    end
    if (a >= 13'h1800) ram_m[a[7:0]] = d;
  endtask

  task automatic do_load(input logic [9:0] la, input logic [7:0] ld);
    load_we = 1'b1; load_addr = la; load_data = ld;
    step();
    load_we = 1'b0;
    rom_m[la] = ld;
  endtask

  // Holds rd for 'hold' edges after acceptance; rdy must appear exactly RD_LAT+1 edges in.
  task automatic do_read(input logic [12:0] a, input int hold, input bit chg, input bit poke);
    logic [7:0] ed;
    bit eu;
    bit er;
    ed = model_read(a);
    eu = model_unmapped(a);
    addr = a; rd = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rd_busy_k0_lat%0d", lat_of(i)), {7'd0, busy_v[i]}, 8'd1);
      check($sformatf("rd_rdy_k0_lat%0d", lat_of(i)), {7'd0, rdy_v[i]}, 8'd0);
    end
    if (chg) addr = 13'($urandom);
    for (int k = 1; k <= hold; k++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        er = (k >= lat_of(i) + 1);
        check($sformatf("rd_rdy_k%0d_lat%0d_a%0h", k, lat_of(i), a), {7'd0, rdy_v[i]}, {7'd0, er});
        check($sformatf("rd_dout_k%0d_lat%0d_a%0h", k, lat_of(i), a), dout_v[i], er ? ed : 8'h00);
        check($sformatf("rd_err_k%0d_lat%0d_a%0h", k, lat_of(i), a), {7'd0, err_v[i]},
              {7'd0, eu && (k == lat_of(i) + 1)});
        check($sformatf("rd_busy_k%0d_lat%0d", k, lat_of(i)), {7'd0, busy_v[i]}, 8'd1);
      end
    end
    if (poke) begin
      wr = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("poke_err_lat%0d", lat_of(i)), {7'd0, err_v[i]}, 8'd1);
        check($sformatf("poke_rdy_lat%0d", lat_of(i)), {7'd0, rdy_v[i]}, 8'd1);
      end
      wr = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("poke_err_off_lat%0d", lat_of(i)), {7'd0, err_v[i]}, 8'd0);
        check($sformatf("poke_dout_lat%0d", lat_of(i)), dout_v[i], ed);
      end
    end
    rd = 1'b0;
    step();
    check_idle("rd_release");
  endtask

  initial begin
    logic [12:0] a;
    logic [9:0]  la;
    logic [7:0]  d;

    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    step();
    step();
    check_idle("reset");
    rst = 1'b0;
    step();

    do_write(13'h1805, 8'hA5);
    do_read(13'h1805, 6, 1'b1, 1'b0);

    do_load(10'h010, 8'h3C);
    do_read(13'h0010, 6, 1'b0, 1'b1);

    do_write(13'h0010, 8'hFF);
    do_read(13'h0010, 6, 1'b0, 1'b0);

    do_read(13'h1805, 3, 1'b0, 1'b0);

    addr = 13'h1805; data_in = 8'h5A; rd = 1'b1; wr = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("both_err_lat%0d", lat_of(i)), {7'd0, err_v[i]}, 8'd1);
      check($sformatf("both_busy_lat%0d", lat_of(i)), {7'd0, busy_v[i]}, 8'd0);
    end
    rd = 1'b0; wr = 1'b0;
    step();
    check_idle("both_after");
    do_read(13'h1805, 6, 1'b0, 1'b0);

    do_read(13'h0400, 6, 1'b0, 1'b0);

    addr = 13'h1805; rd = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    check_idle("rst_mid_read");
    rst = 1'b0; rd = 1'b0;
    step();

    addr = 13'h1805; data_in = 8'h77; wr = 1'b1;
    step();
    wr = 1'b0; rst = 1'b1;
    step();
    check_idle("rst_mid_write");
    rst = 1'b0;
    step();
    do_read(13'h1805, 6, 1'b0, 1'b0);

    repeat (8) begin
      a = {2'b11, 11'($urandom)};
      d = 8'($urandom);
      do_write(a, d);
      do_read(a, 6, 1'b1, 1'($urandom_range(0, 1)));
    end

    repeat (6) begin
      la = 10'($urandom);
      d  = 8'($urandom);
      do_load(la, d);
      do_read({3'b000, la}, 6, 1'b1, 1'b0);
    end

    repeat (4) begin
      a = 13'($urandom_range(32'h0400, 32'h17FF));
      do_read(a, 6, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
